// File: rtl/rom_load_pkg.sv
// Shared types and widths for the ROM download sequencer.
// Region geometry defaults match the arcade core's ROM map.
package rom_load_pkg;

    localparam int                ADDR_W       = 25;
    localparam int                DATA_W       = 8;
    localparam int                REG_IDX_W    = 3;
    localparam int                DEF_NREG     = 8;
    localparam int                DEF_RSHIFT   = 15;
    localparam int                DEF_HOLD_CYC = 1024;
    localparam logic [ADDR_W-1:0] DEF_EXP_SIZE = 25'h40000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_HOLD,
        ST_FAIL,
        ST_RUN
    } state_e;

    // Byte counter saturates so an overlong stream can never alias back to a legal count.
    function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
        return (&v) ? v : v + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/rom_load_sequencer_if.sv
// HPS ioctl download stream in, core ROM write port out.
// master = HPS side / stimulus, slave = sequencer.
interface rom_load_sequencer_if
    import rom_load_pkg::*;
#(
    parameter int NREG   = DEF_NREG,
    parameter int RSHIFT = DEF_RSHIFT
);

    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [DATA_W-1:0] ioctl_dout;

    logic [RSHIFT-1:0] ROMAD;
    logic [DATA_W-1:0] ROMDT;
    logic [NREG-1:0]   ROMEN;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ROMAD, ROMDT, ROMEN
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output ROMAD, ROMDT, ROMEN
    );

endinterface

// File: rtl/rom_region_decode.sv
// Splits a ROM byte address into a one-hot region select and an in-region offset.
// Only the region and offset bits are presented; the full-range check lives in the sequencer.
module rom_region_decode
    import rom_load_pkg::*;
#(
    parameter int NREG   = DEF_NREG,
    parameter int RSHIFT = DEF_RSHIFT
) (
    input  logic [RSHIFT+REG_IDX_W-1:0] addr_i,
    output logic [NREG-1:0]             region_oh_o,
    output logic [RSHIFT-1:0]           offset_o,
    output logic                        in_range_o
);

    logic [REG_IDX_W-1:0] idx;

    always_comb begin
        idx         = addr_i[RSHIFT +: REG_IDX_W];
        offset_o    = addr_i[RSHIFT-1:0];
        in_range_o  = (int'(idx) < NREG);
        region_oh_o = '0;
        for (int r = 0; r < NREG; r++) begin
            region_oh_o[r] = in_range_o && (int'(idx) == r);
        end
    end

endmodule

// File: rtl/rom_load_sequencer.sv
// Routes the HPS ROM download into the core's ROM regions, validates the stream,
// and owns core reset so the core only runs after a clean, complete load.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | power-up, no download seen yet, core held in reset
//   ST_LOAD  | download active, bytes checked and forwarded
//   ST_CHECK | one cycle to judge error flag and final byte count
//   ST_HOLD  | clean load, core reset held for HOLD_CYC settle cycles
//   ST_FAIL  | bad load, core stays in reset until the next download
//   ST_RUN   | core released, LOAD_OK set
module rom_load_sequencer
    import rom_load_pkg::*;
#(
    parameter int                NREG     = DEF_NREG,
    parameter int                RSHIFT   = DEF_RSHIFT,
    parameter logic [ADDR_W-1:0] EXP_SIZE = DEF_EXP_SIZE,
    parameter int                HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic                 MCLK,
    input  logic                 RESET,
    rom_load_sequencer_if.slave  bus,
    output logic                 CORE_RST,
    output logic                 LOAD_OK,
    output logic                 LOAD_ERR
);

    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              err_q;
    logic [HOLD_W-1:0] hold_q;
    logic [RSHIFT-1:0] romad_q;
    logic [DATA_W-1:0] romdt_q;
    logic [NREG-1:0]   romen_q;
    logic              load_ok_q;
    logic              load_err_q;

    logic [NREG-1:0]   dec_oh;
    logic [RSHIFT-1:0] dec_off;
    logic              dec_in_range;
    logic              byte_ok;

    rom_region_decode #(
        .NREG   (NREG),
        .RSHIFT (RSHIFT)
    ) u_decode (
        .addr_i      (bus.ioctl_addr[RSHIFT+REG_IDX_W-1:0]),
        .region_oh_o (dec_oh),
        .offset_o    (dec_off),
        .in_range_o  (dec_in_range)
    );

    assign byte_ok = dec_in_range
                  && (bus.ioctl_addr == cnt_q)
                  && (bus.ioctl_addr < EXP_SIZE);

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            hold_q     <= '0;
            romad_q    <= '0;
            romdt_q    <= '0;
            romen_q    <= '0;
            load_ok_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            romen_q <= '0;
            case (state_q)
                ST_IDLE, ST_HOLD, ST_RUN, ST_FAIL: begin
                    // A new download always wins, even mid-settle.
                    if (bus.ioctl_download) begin
                        state_q    <= ST_LOAD;
                        cnt_q      <= '0;
                        err_q      <= 1'b0;
                        load_ok_q  <= 1'b0;
                        load_err_q <= 1'b0;
                    end else if (state_q == ST_HOLD) begin
                        if (hold_q == '0) begin
                            state_q   <= ST_RUN;
                            load_ok_q <= 1'b1;
                        end else begin
                            hold_q <= hold_q - HOLD_W'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    // The byte that coincides with download falling is still taken.
                    if (bus.ioctl_wr) begin
                        romad_q <= dec_off;
                        romdt_q <= bus.ioctl_dout;
                        romen_q <= byte_ok ? dec_oh : '0;
                        cnt_q   <= sat_inc(cnt_q);
                        if (!byte_ok) begin
                            err_q <= 1'b1;
                        end
                    end
                    if (!bus.ioctl_download) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!err_q && (cnt_q == EXP_SIZE)) begin
                        state_q <= ST_HOLD;
                        hold_q  <= HOLD_W'(HOLD_CYC - 1);
                    end else begin
                        state_q    <= ST_FAIL;
                        load_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ROMAD = romad_q;
    assign bus.ROMDT = romdt_q;
    assign bus.ROMEN = romen_q;
    assign CORE_RST  = (state_q != ST_RUN);
    assign LOAD_OK   = load_ok_q;
    assign LOAD_ERR  = load_err_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Randomised download streams against a byte-level reference model; a scoreboard
// monitor matches every ROMEN pulse, and status/timing is checked after each load.
module tb_rom_load_sequencer;
    import rom_load_pkg::*;

    localparam int                NREG     = 8;
    localparam int                RSHIFT   = 6;
    localparam int                HOLD_CYC = 16;
    localparam logic [ADDR_W-1:0] EXP_SIZE = 25'h180;
    localparam int                EXP_N    = int'(EXP_SIZE);

    typedef struct {
        logic [NREG-1:0]   en;
        logic [RSHIFT-1:0] ad;
        logic [7:0]        dt;
        longint            cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   core_rst, load_ok, load_err;
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;
    exp_t   sb[$];

    rom_load_sequencer_if #(.NREG(NREG), .RSHIFT(RSHIFT)) bus ();

    rom_load_sequencer #(
        .NREG     (NREG),
        .RSHIFT   (RSHIFT),
        .EXP_SIZE (EXP_SIZE),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .MCLK     (clk),
        .RESET    (rst),
        .bus      (bus),
        .CORE_RST (core_rst),
        .LOAD_OK  (load_ok),
        .LOAD_ERR (load_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (bus.ROMEN != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_romen", longint'(bus.ROMEN), 0);
                end else begin
                    e = sb.pop_front();
                    check("romen_onehot", longint'(bus.ROMEN), longint'(e.en));
                    check("romad",        longint'(bus.ROMAD), longint'(e.ad));
                    check("romdt",        longint'(bus.ROMDT), longint'(e.dt));
                    check("romen_cycle",  cyc,                 e.cyc);
                end
            end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                check("romen_missing", longint'(bus.ROMEN), longint'(e.en));
            end
        end
    endtask

    // Reference rule: byte i is written iff its address equals i, lies below EXP_SIZE
    // and maps to an existing region; the load is good iff all bytes pass and i hits EXP_SIZE.
    task automatic model_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d,
                              input int idx, inout bit merr);
        exp_t e;
        int   region;
        region = int'(a >> RSHIFT);
        if (a == ADDR_W'(idx) && a < EXP_SIZE && region < NREG) begin
            e.en         = '0;
            e.en[region] = 1'b1;
            e.ad         = a[RSHIFT-1:0];
            e.dt         = d;
            e.cyc        = cyc + 1;
            sb.push_back(e);
        end else begin
            merr = 1'b1;
        end
    endtask

    task automatic run_load(input int n, input int skip, input bit rise_wr,
                            output bit ok, output longint c0);
        bit               merr;
        int               low_cnt;
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
        merr    = 1'b0;
        low_cnt = 0;
        bus.ioctl_download = 1'b1;
        if (rise_wr) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = '0;
            bus.ioctl_dout = 8'hA5;
        end
        tick();
        bus.ioctl_wr = 1'b0;
        if (!core_rst) low_cnt++;
        c0 = cyc;
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                if (!core_rst) low_cnt++;
            end
            a = (skip >= 0 && i >= skip) ? ADDR_W'(i + 1) : ADDR_W'(i);
            d = 8'($urandom);
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = a;
            bus.ioctl_dout = d;
            model_byte(a, d, i, merr);
            if (i == n - 1 && $urandom_range(0, 1) == 1) begin
                bus.ioctl_download = 1'b0;
                c0 = cyc;
            end
            tick();
            bus.ioctl_wr = 1'b0;
            if (!core_rst) low_cnt++;
        end
        if (bus.ioctl_download) begin
            bus.ioctl_download = 1'b0;
            c0 = cyc;
        end
        check("core_rst_during_load", low_cnt, 0);
        ok = !merr && (n == EXP_N);
    endtask

    task automatic finish_load(input bit ok, input longint c0);
        longint first_run;
        first_run = -1;
        for (int k = 0; k < HOLD_CYC + 6; k++) begin
            @(negedge clk);
            if (first_run < 0 && !core_rst) first_run = cyc;
        end
        if (ok) begin
            check("run_release_cycle", first_run, c0 + HOLD_CYC + 2);
            check("load_ok_after_good", longint'(load_ok), 1);
            check("load_err_after_good", longint'(load_err), 0);
        end else begin
            check("core_rst_held_on_bad", first_run, -1);
            check("load_err_after_bad", longint'(load_err), 1);
            check("load_ok_after_bad", longint'(load_ok), 0);
            check("state_fail", longint'(dut.state_q), longint'(ST_FAIL));
        end
        tick();
    endtask

    initial begin
        bit     ok;
        longint c0;
        int     dropped;
        logic [7:0] d;

        rst                = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_romad",    longint'(bus.ROMAD), 0);
        check("reset_romdt",    longint'(bus.ROMDT), 0);
        check("reset_romen",    longint'(bus.ROMEN), 0);
        check("reset_core_rst", longint'(core_rst),  1);
        check("reset_load_ok",  longint'(load_ok),   0);
        check("reset_load_err", longint'(load_err),  0);
        check("reset_state",    longint'(dut.state_q), longint'(ST_IDLE));
        tick();
        rst = 1'b0;
        tick();

        // Full clean load, with a stray write on the download-rise cycle.
        run_load(EXP_N, -1, 1'b1, ok, c0);
        finish_load(ok, c0);

        // One byte short.
        run_load(EXP_N - 1, -1, 1'b0, ok, c0);
        finish_load(ok, c0);

        // Address jump 0x0FF -> 0x101.
        run_load(EXP_N, 32'h100, 1'b0, ok, c0);
        finish_load(ok, c0);

        // Re-assert download ten cycles into the settle period.
        run_load(EXP_N, -1, 1'b0, ok, c0);
        dropped = 0;
        repeat (12) begin
            tick();
            if (!core_rst) dropped++;
        end
        check("core_rst_hold_reassert", dropped, 0);
        run_load(EXP_N, -1, 1'b0, ok, c0);
        finish_load(ok, c0);

        // Reset asserted on a write cycle mid-load.
        bus.ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 50; i++) begin
            bit merr;
            merr = 1'b0;
            d = 8'($urandom);
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = ADDR_W'(i);
            bus.ioctl_dout = d;
            model_byte(ADDR_W'(i), d, i, merr);
            tick();
            bus.ioctl_wr = 1'b0;
        end
        tick();
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = ADDR_W'(50);
        bus.ioctl_dout = 8'h3C;
        rst            = 1'b1;
        @(negedge clk);
        check("rst_mid_load_romen",    longint'(bus.ROMEN), 0);
        check("rst_mid_load_core_rst", longint'(core_rst),  1);
        check("rst_mid_load_state",    longint'(dut.state_q), longint'(ST_IDLE));
        tick();
        rst                = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        tick();
        run_load(EXP_N, -1, 1'b0, ok, c0);
        finish_load(ok, c0);

        // Writes while running with no download active.
        repeat (6) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = ADDR_W'($urandom_range(0, EXP_N - 1));
            bus.ioctl_dout = 8'($urandom);
            tick();
            bus.ioctl_wr = 1'b0;
            tick();
        end
        check("run_wr_core_rst", longint'(core_rst), 0);
        check("run_wr_load_ok",  longint'(load_ok),  1);
        check("run_wr_load_err", longint'(load_err), 0);

        repeat (3) tick();
        check("scoreboard_drained", longint'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
